// File: rtl/speed_sched.sv
// Playback-speed scheduler: forwards or drops each valid audio sample using a
// fractional phase accumulator so decimation runs from 1.0x to 15.94x in 1/16 steps.
//
// state | meaning
// IDLE  | no sample seen since reset; next sample is forwarded unconditionally
// RUN   | normal decimation with speed_active
// PEND  | new speed captured; waits for the next sample to switch on
module speed_sched #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEFAULT_SPEED = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] audio_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] audio_out,
    output logic                  valid_out,
    input  logic [7:0]            cfg_speed,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [7:0]            speed_active
);

    localparam logic [7:0] SPEED_RST = 8'(DEFAULT_SPEED);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t      state;
    logic [8:0]  acc;
    logic [7:0]  speed_pend;
    logic        cfg_accept;
    logic [8:0]  sum;
    logic [8:0]  speed_ext;
    logic [7:0]  cfg_clamped;

    assign cfg_accept  = cfg_valid && cfg_ready;
    assign sum         = acc + 9'd16;
    assign speed_ext   = {1'b0, speed_active};
    assign cfg_clamped = (cfg_speed < 8'd16) ? 8'd16 : cfg_speed;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            acc          <= '0;
            audio_out    <= '0;
            valid_out    <= 1'b0;
            speed_active <= SPEED_RST;
            speed_pend   <= SPEED_RST;
            cfg_ready    <= 1'b1;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        audio_out <= audio_in;
                        valid_out <= 1'b1;
                        acc       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (valid_in) begin
                        if (sum >= speed_ext) begin
                            audio_out <= audio_in;
                            valid_out <= 1'b1;
                            acc       <= sum - speed_ext;
                        end else begin
                            acc <= sum;
                        end
                    end
                end
                PEND: begin
                    if (valid_in) begin
                        speed_active <= speed_pend;
                        acc          <= '0;
                        audio_out    <= audio_in;
                        valid_out    <= 1'b1;
                        cfg_ready    <= 1'b1;
                        state        <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
            // A request accepted alongside a sample still lets that sample use the old speed above.
            if (cfg_accept) begin
                speed_pend <= cfg_clamped;
                cfg_ready  <= 1'b0;
                state      <= PEND;
            end
        end
    end

endmodule

// File: tb/tb_speed_sched.sv
// Randomized and directed bench for speed_sched, checked against a phase-count
// reference model (forward when floor(16*n/speed) advances since the last switch).
module tb_speed_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] audio_in;
    logic        valid_in;
    logic [31:0] audio_out;
    logic        valid_out;
    logic [7:0]  cfg_speed;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  speed_active;

    always #5 clk = ~clk;

    speed_sched #(.DATA_WIDTH(32), .DEFAULT_SPEED(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .audio_in     (audio_in),
        .valid_in     (valid_in),
        .audio_out    (audio_out),
        .valid_out    (valid_out),
        .cfg_speed    (cfg_speed),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .speed_active (speed_active)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    bit          m_started;
    bit          m_pend;
    int          m_n;
    int          m_speed;
    int          m_pend_speed;
    logic [31:0] m_out;
    bit          m_vout;
    bit          accepted;
    int          fwd_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started    = 0;
        m_pend       = 0;
        m_n          = 0;
        m_speed      = 32;
        m_pend_speed = 32;
        m_out        = '0;
        m_vout       = 0;
    endtask

    task automatic step(input bit rst, input bit v, input logic [31:0] d, input bit cv, input logic [7:0] cs);
        bit fwd;
        reset_n   = !rst;
        valid_in  = v;
        audio_in  = d;
        cfg_valid = cv;
        cfg_speed = cs;
        @(posedge clk);
        accepted = 0;
        fwd      = 0;
        if (rst) begin
            model_reset();
        end else begin
            accepted = cv && !m_pend;
            if (v) begin
                if (m_pend) begin
                    m_speed   = m_pend_speed;
                    m_pend    = 0;
                    m_started = 1;
                    m_n       = 0;
                    fwd       = 1;
                end else if (!m_started) begin
                    m_started = 1;
                    m_n       = 0;
                    fwd       = 1;
                end else begin
                    m_n++;
                    fwd = ((m_n * 16) / m_speed) != (((m_n - 1) * 16) / m_speed);
                end
            end
            if (accepted) begin
                m_pend       = 1;
                m_pend_speed = (cs < 16) ? 16 : int'(cs);
            end
            m_vout = fwd;
            if (fwd) m_out = d;
        end
        #1;
        check("valid_out", {31'd0, valid_out}, {31'd0, m_vout});
        check("audio_out", audio_out, m_out);
        check("cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_pend});
        check("speed_active", {24'd0, speed_active}, 32'(m_speed));
        if (valid_out) fwd_q.push_back(int'(audio_out));
    endtask

    initial begin
        int exp_frac[6];
        bit req_on;
        logic [7:0] req_speed;
        bit rst;
        exp_frac = '{10, 12, 13, 15, 16, 18};
        reset_n = 1'b0; valid_in = 1'b0; audio_in = '0; cfg_valid = 1'b0; cfg_speed = '0;
        model_reset();

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("reset_speed", {24'd0, speed_active}, 32'd32);
        check("reset_ready", {31'd0, cfg_ready}, 32'd1);

        // default 2x
        fwd_q.delete();
        for (int i = 0; i < 8; i++) step(0, 1, 32'(i), 0, 0);
        check("2x_count", 32'(fwd_q.size()), 32'd4);
        for (int i = 0; i < fwd_q.size() && i < 4; i++) check("2x_value", 32'(fwd_q[i]), 32'(2 * i));

        // fractional 1.5x
        step(0, 0, 0, 1, 8'd24);
        fwd_q.delete();
        for (int i = 10; i <= 18; i++) step(0, 1, 32'(i), 0, 0);
        check("frac_count", 32'(fwd_q.size()), 32'd6);
        for (int i = 0; i < fwd_q.size() && i < 6; i++) check("frac_value", 32'(fwd_q[i]), 32'(exp_frac[i]));

        // clamp to 1x
        step(0, 0, 0, 1, 8'd5);
        fwd_q.delete();
        for (int i = 0; i < 4; i++) step(0, 1, 32'(100 + i), 0, 0);
        check("clamp_speed", {24'd0, speed_active}, 32'd16);
        check("clamp_count", 32'(fwd_q.size()), 32'd4);

        // handshake: held request, no samples
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 8'd40);
        check("hs_ready_low", {31'd0, cfg_ready}, 32'd0);
        check("hs_speed_held", {24'd0, speed_active}, 32'd16);
        step(0, 1, 32'd200, 0, 0);
        check("hs_speed_new", {24'd0, speed_active}, 32'd40);
        check("hs_ready_back", {31'd0, cfg_ready}, 32'd1);

        // simultaneous sample and config at acc=16, speed 32
        step(1, 0, 0, 0, 0);
        step(0, 1, 32'd300, 0, 0);
        step(0, 1, 32'd301, 0, 0);
        fwd_q.delete();
        step(0, 1, 32'd302, 1, 8'd48);
        check("sim_fwd_old", {31'd0, valid_out}, 32'd1);
        for (int i = 303; i < 311; i++) step(0, 1, 32'(i), 0, 0);
        check("sim_count", 32'(fwd_q.size()), 32'd4);

        // reset while pending with samples streaming
        step(0, 0, 0, 1, 8'd64);
        step(1, 1, 32'd400, 0, 0);
        check("rst_vout", {31'd0, valid_out}, 32'd0);
        check("rst_speed", {24'd0, speed_active}, 32'd32);
        step(0, 1, 32'd401, 0, 0);
        check("rst_first_fwd", audio_out, 32'd401);

        // randomized traffic
        req_on = 0;
        req_speed = '0;
        for (int i = 0; i < 4000; i++) begin
            if (!req_on && $urandom_range(0, 29) == 0) begin
                req_on    = 1;
                req_speed = 8'($urandom_range(0, 255));
            end
            rst = ($urandom_range(0, 499) == 0);
            step(rst, ($urandom_range(0, 3) != 0), $urandom, req_on, req_speed);
            if (accepted || rst) req_on = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
